// File: rtl/Global_defines.sv
// rtl/Global_defines.sv - shared definitions for the memory request controller
// Purpose: FSM state encoding and default timeout depth shared by
//          mem_req_ctrl and mem_timeout_cnt.
// Ports:   none (package).
package Global_defines;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - saturating WAIT-cycle counter for the request timeout
// Purpose: counts WAIT cycles and flags the last allowed WAIT cycle.
//          Only exists when MEM_REQ_CTRL_TIMEOUT_EN is defined.
// Ports:   clk, reset (async active-low), clr (restart count),
//          en (WAIT cycle in progress), expired (this is the final WAIT cycle).
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
module mem_timeout_cnt
  import Global_defines::*;
#(
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of WAIT cycles already completed, so the
  // TIMEOUT_CYCLES-th WAIT cycle is the one where cnt == LIMIT-1.
  assign expired = en && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding CPU-to-memory request controller
// Purpose: accepts one CPU read/write, issues it to memory for one cycle,
//          waits for mem_data_valid and returns a one-cycle response.
//          Optional timeout: define MEM_REQ_CTRL_TIMEOUT_EN.
// Ports:   clk, reset (async active-low)
//          cpu_req_valid/ready/we/addr/wdata   CPU request
//          cpu_resp_valid/rdata/err            CPU response (no backpressure)
//          mem_addr/mem_req_valid/mem_we       memory request
//          mem_data (shared bus), mem_data_valid (memory completion)
module mem_req_ctrl
  import Global_defines::*;
#(
  parameter int  MEM_DEPTH      = 8,
  parameter int  DATA_WIDTH     = 32,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  cpu_resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_data_valid
);

  state_t                state, next_state;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  timeout;
  logic                  done;

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  logic err_q;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ST_REQ),
    .en     (state == ST_WAIT),
    .expired(timeout)
  );

  // A completion arriving in the same cycle as expiry wins: err stays 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (mem_data_valid) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cpu_resp_err = err_q;
`else
  assign timeout      = 1'b0;
  assign cpu_resp_err = 1'b0;
`endif

  assign done = mem_data_valid || timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= next_state;
      if ((state == ST_IDLE) && cpu_req_valid) begin
        req_we    <= cpu_req_we;
        req_addr  <= cpu_req_addr;
        req_wdata <= cpu_req_wdata;
      end
      if (state == ST_WAIT) begin
        if (mem_data_valid) begin
          rdata_q <= req_we ? '0 : mem_data;
        end else if (timeout) begin
          rdata_q <= '0;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (cpu_req_valid) next_state = ST_REQ;
      ST_REQ:  next_state = ST_WAIT;
      ST_WAIT: if (done) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // ready is gated by reset so it reads 0 while reset is held even though
  // the state register already sits in IDLE.
  assign cpu_req_ready  = (state == ST_IDLE) && reset;
  assign cpu_resp_valid = (state == ST_RESP);
  assign cpu_resp_rdata = rdata_q;
  assign mem_req_valid  = (state == ST_REQ);
  assign mem_we         = (state == ST_REQ) && req_we;
  assign mem_addr       = req_addr;
  assign mem_data       = ((state == ST_REQ) && req_we) ? req_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [2:0]  cpu_req_addr = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;
  logic [2:0]  mem_addr;
  logic        mem_req_valid;
  logic        mem_we;
  wire  [31:0] mem_data;
  logic        mem_data_valid = 1'b0;

  logic        tb_drv = 1'b0;
  logic [31:0] tb_val = '0;
  logic [31:0] tb_mem [8];

  int n_vec = 0;
  int n_bad = 0;
  int resp_cnt = 0;
  int cnt_before;

  assign mem_data = tb_drv ? tb_val : 32'bz;

  always #5 clk = ~clk;

  always @(posedge clk) if (cpu_resp_valid) resp_cnt++;

  mem_req_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .cpu_resp_err  (cpu_resp_err),
    .mem_addr      (mem_addr),
    .mem_req_valid (mem_req_valid),
    .mem_we        (mem_we),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with a memory that completes in the second WAIT cycle.
  task automatic do_txn(input logic we, input logic [2:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string tag);
    chk({tag, " ready"}, cpu_req_ready, 1);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd;
    step();                                    // edge 0: accept
    cpu_req_valid = 1'b0;
    chk({tag, " req_valid"}, mem_req_valid, 1);
    chk({tag, " mem_addr"}, mem_addr, a);
    chk({tag, " mem_we"}, mem_we, we);
    chk({tag, " busy"}, cpu_req_ready, 0);
    if (we) begin
      chk({tag, " wdata on bus"}, mem_data, wd);
      tb_mem[a] = wd;
    end else begin
      chk({tag, " bus idle in read REQ"}, mem_data !== wd, 1);
    end
    step();                                    // edge 1: WAIT
    chk({tag, " req pulse ends"}, mem_req_valid, 0);
    chk({tag, " bus released"}, mem_data !== wd, 1);
    chk({tag, " no early resp"}, cpu_resp_valid, 0);
    step();                                    // edge 2: still WAIT
    chk({tag, " no resp edge2"}, cpu_resp_valid, 0);
    mem_data_valid = 1'b1;
    if (!we) begin tb_drv = 1'b1; tb_val = tb_mem[a]; end
    step();                                    // edge 3: RESP
    mem_data_valid = 1'b0; tb_drv = 1'b0;
    chk({tag, " resp_valid"}, cpu_resp_valid, 1);
    chk({tag, " rdata"}, cpu_resp_rdata, exp_rd);
    chk({tag, " err"}, cpu_resp_err, 0);
    step();                                    // edge 4: IDLE
    chk({tag, " resp one cycle"}, cpu_resp_valid, 0);
    chk({tag, " ready again"}, cpu_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) tb_mem[i] = i;

    // Reset values
    step(); step();
    chk("rst ready", cpu_req_ready, 0);
    chk("rst resp_valid", cpu_resp_valid, 0);
    chk("rst rdata", cpu_resp_rdata, 0);
    chk("rst err", cpu_resp_err, 0);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    reset = 1'b1;
    step();
    chk("ready after reset", cpu_req_ready, 1);

    // mem_data_valid outside WAIT is ignored
    mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    chk("dv in idle ignored", cpu_resp_valid, 0);
    chk("dv in idle ready", cpu_req_ready, 1);

    // Read, write, read-back
    do_txn(1'b0, 3'd5, 32'hA5A5_A5A5, 32'd5, "rd5");
    do_txn(1'b1, 3'd3, 32'hDEAD_BEEF, 32'd0, "wr3");
    do_txn(1'b0, 3'd3, 32'h1234_5678, 32'hDEAD_BEEF, "rd3");

    // Second request held high while busy
    cnt_before = resp_cnt;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 3'd1; cpu_req_wdata = '0;
    step();                                    // accept A
    cpu_req_addr = 3'd2;
    chk("b2b A addr", mem_addr, 1);
    chk("b2b ready REQ", cpu_req_ready, 0);
    step();
    chk("b2b ready WAIT", cpu_req_ready, 0);
    step();
    mem_data_valid = 1'b1; tb_drv = 1'b1; tb_val = tb_mem[1];
    step();                                    // RESP A
    mem_data_valid = 1'b0; tb_drv = 1'b0;
    chk("b2b A resp", cpu_resp_valid, 1);
    chk("b2b A rdata", cpu_resp_rdata, 1);
    chk("b2b ready RESP", cpu_req_ready, 0);
    step();                                    // IDLE
    chk("b2b ready IDLE", cpu_req_ready, 1);
    chk("b2b no resp IDLE", cpu_resp_valid, 0);
    step();                                    // accept B
    cpu_req_valid = 1'b0;
    chk("b2b B req", mem_req_valid, 1);
    chk("b2b B addr", mem_addr, 2);
    step();
    step();
    mem_data_valid = 1'b1; tb_drv = 1'b1; tb_val = tb_mem[2];
    step();                                    // RESP B
    mem_data_valid = 1'b0; tb_drv = 1'b0;
    chk("b2b B resp", cpu_resp_valid, 1);
    chk("b2b B rdata", cpu_resp_rdata, 2);
    step();
    chk("b2b two pulses", resp_cnt - cnt_before, 2);

    // Memory never completes
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 3'd4;
    step();                                    // edge 0
    cpu_req_valid = 1'b0;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("to waiting", cpu_resp_valid, 0);
    end
    step();                                    // edge 16
    chk("to resp", cpu_resp_valid, 1);
    chk("to err", cpu_resp_err, 1);
    chk("to rdata", cpu_resp_rdata, 0);
    step();
    chk("to ready", cpu_req_ready, 1);
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("stall waiting", cpu_resp_valid, 0);
    end
    mem_data_valid = 1'b1; tb_drv = 1'b1; tb_val = tb_mem[4];
    step();
    mem_data_valid = 1'b0; tb_drv = 1'b0;
    chk("stall resp", cpu_resp_valid, 1);
    chk("stall rdata", cpu_resp_rdata, 4);
    chk("stall err", cpu_resp_err, 0);
    step();
    chk("stall ready", cpu_req_ready, 1);
`endif

    // Reset during WAIT drops the request
    cnt_before = resp_cnt;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 3'd6;
    step();
    cpu_req_valid = 1'b0;
    step();
    step();                                    // in WAIT
    reset = 1'b0;
    mem_data_valid = 1'b1; tb_drv = 1'b1; tb_val = tb_mem[6];
    #1;
    chk("mid rst ready", cpu_req_ready, 0);
    chk("mid rst resp_valid", cpu_resp_valid, 0);
    chk("mid rst rdata", cpu_resp_rdata, 0);
    chk("mid rst err", cpu_resp_err, 0);
    chk("mid rst mem_req_valid", mem_req_valid, 0);
    chk("mid rst mem_we", mem_we, 0);
    chk("mid rst mem_addr", mem_addr, 0);
    step(); step();
    mem_data_valid = 1'b0; tb_drv = 1'b0;
    reset = 1'b1;
    step();
    chk("post rst ready", cpu_req_ready, 1);
    chk("post rst no resp", cpu_resp_valid, 0);
    step(); step();
    chk("post rst no pulse", resp_cnt - cnt_before, 0);
    chk("post rst rdata", cpu_resp_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
